// File: rtl/mmio_issue_sched_if.sv
// Uncache request/response channel between the MMIO issue scheduler and the uncache port.
interface mmio_issue_sched_if #(
    parameter int unsigned ROB_IDX_W = 8
);
    logic                 uncache_req_valid;
    logic                 uncache_req_ready;
    logic [ROB_IDX_W-1:0] uncache_req_robIdx;
    logic [1:0]           uncache_req_lane;
    logic                 uncache_resp_valid;

    // Scheduler side: issues requests, consumes ready and response.
    modport master (
        output uncache_req_valid,
        output uncache_req_robIdx,
        output uncache_req_lane,
        input  uncache_req_ready,
        input  uncache_resp_valid
    );

    // Uncache side: accepts requests, returns responses.
    modport slave (
        input  uncache_req_valid,
        input  uncache_req_robIdx,
        input  uncache_req_lane,
        output uncache_req_ready,
        output uncache_resp_valid
    );
endinterface

// File: rtl/mmio_issue_sched.sv
// Non-speculative MMIO issue scheduler: parks one MMIO uop per LSQ lane and issues
// the slot whose robIdx is at the ROB head, one access outstanding at a time.
module mmio_issue_sched #(
    parameter int unsigned ROB_IDX_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 io_lsq_mmio_0,
    input  logic                 io_lsq_mmio_1,
    input  logic                 io_lsq_mmio_2,
    input  logic [ROB_IDX_W-1:0] io_lsq_uop_0_robIdx_value,
    input  logic [ROB_IDX_W-1:0] io_lsq_uop_1_robIdx_value,
    input  logic [ROB_IDX_W-1:0] io_lsq_uop_2_robIdx_value,
    output logic                 io_lsq_ready_0,
    output logic                 io_lsq_ready_1,
    output logic                 io_lsq_ready_2,
    input  logic [ROB_IDX_W-1:0] rob_head,
    input  logic                 flush_valid,
    input  logic [ROB_IDX_W-1:0] flush_robIdx,
    mmio_issue_sched_if.master   unc,
    output logic                 wb_valid,
    output logic [ROB_IDX_W-1:0] wb_robIdx,
    output logic [1:0]           wb_lane,
    output logic                 busy
);
    localparam int unsigned NUM_LANES = 3;
    localparam int unsigned LANE_W    = 2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

    state_t                 state, state_nxt;
    logic [LANE_W-1:0]      sel, sel_nxt;
    logic [NUM_LANES-1:0]   slot_valid, slot_valid_nxt;
    logic [ROB_IDX_W-1:0]   slot_idx     [NUM_LANES];
    logic [ROB_IDX_W-1:0]   slot_idx_nxt [NUM_LANES];
    logic [NUM_LANES-1:0]   mmio_in;
    logic [ROB_IDX_W-1:0]   in_idx       [NUM_LANES];
    logic [NUM_LANES-1:0]   protect, kill, cand;
    logic [ROB_IDX_W-1:0]   flush_age;
    logic                   hs;

    logic [NUM_LANES-1:0]   ready_q;
    logic                   req_valid_q;
    logic [ROB_IDX_W-1:0]   req_robidx_q;
    logic [LANE_W-1:0]      req_lane_q;

    // Distance from the ROB head; older uops have smaller age, wrap handled by modulo.
    function automatic logic [ROB_IDX_W-1:0] age(input logic [ROB_IDX_W-1:0] x,
                                                 input logic [ROB_IDX_W-1:0] head);
        return ROB_IDX_W'(x - head);
    endfunction

    assign mmio_in   = {io_lsq_mmio_2, io_lsq_mmio_1, io_lsq_mmio_0};
    assign in_idx[0] = io_lsq_uop_0_robIdx_value;
    assign in_idx[1] = io_lsq_uop_1_robIdx_value;
    assign in_idx[2] = io_lsq_uop_2_robIdx_value;

    assign io_lsq_ready_0         = ready_q[0];
    assign io_lsq_ready_1         = ready_q[1];
    assign io_lsq_ready_2         = ready_q[2];
    assign unc.uncache_req_valid  = req_valid_q;
    assign unc.uncache_req_robIdx = req_robidx_q;
    assign unc.uncache_req_lane   = req_lane_q;

    // Next-state, slot update, flush kill and head-match selection.
    always_comb begin
        state_nxt      = state;
        sel_nxt        = sel;
        slot_valid_nxt = slot_valid;
        slot_idx_nxt   = slot_idx;
        protect        = '0;
        kill           = '0;
        cand           = '0;
        flush_age      = age(flush_robIdx, rob_head);
        hs             = (state == REQ) && unc.uncache_req_ready;

        for (int i = 0; i < NUM_LANES; i++) begin
            // The in-flight slot survives flushes once the access has left the block.
            protect[i] = (sel == LANE_W'(i)) && ((state == WAIT) || (state == WB) || hs);
            kill[i]    = flush_valid && slot_valid[i] && !protect[i]
                         && (age(slot_idx[i], rob_head) >= flush_age);
            cand[i]    = slot_valid[i] && !kill[i] && (slot_idx[i] == rob_head);
        end

        case (state)
            IDLE: begin
                if (cand[0]) begin
                    sel_nxt   = 2'd0;
                    state_nxt = REQ;
                end else if (cand[1]) begin
                    sel_nxt   = 2'd1;
                    state_nxt = REQ;
                end else if (cand[2]) begin
                    sel_nxt   = 2'd2;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (hs) begin
                    state_nxt = WAIT;
                end else if (kill[sel]) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (unc.uncache_resp_valid) begin
                    state_nxt = WB;
                end
            end
            WB: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        for (int i = 0; i < NUM_LANES; i++) begin
            if (kill[i] || ((state == WB) && (sel == LANE_W'(i)))) begin
                slot_valid_nxt[i] = 1'b0;
            end
            if (!slot_valid[i] && mmio_in[i]
                && !(flush_valid && (age(in_idx[i], rob_head) >= flush_age))) begin
                slot_valid_nxt[i] = 1'b1;
                slot_idx_nxt[i]   = in_idx[i];
            end
        end
    end

    // State, slots and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sel          <= '0;
            slot_valid   <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                slot_idx[i] <= '0;
            end
            ready_q      <= '1;
            req_valid_q  <= 1'b0;
            req_robidx_q <= '0;
            req_lane_q   <= '0;
            wb_valid     <= 1'b0;
            wb_robIdx    <= '0;
            wb_lane      <= '0;
            busy         <= 1'b0;
        end else begin
            state       <= state_nxt;
            sel         <= sel_nxt;
            slot_valid  <= slot_valid_nxt;
            slot_idx    <= slot_idx_nxt;
            ready_q     <= ~slot_valid_nxt;
            req_valid_q <= (state_nxt == REQ);
            wb_valid    <= (state_nxt == WB);
            busy        <= (state_nxt != IDLE);
            if ((state == IDLE) && (state_nxt == REQ)) begin
                req_robidx_q <= slot_idx[sel_nxt];
                req_lane_q   <= sel_nxt;
            end
            if ((state == WAIT) && (state_nxt == WB)) begin
                wb_robIdx <= slot_idx[sel];
                wb_lane   <= sel;
            end
        end
    end
endmodule

// File: tb/tb_mmio_issue_sched.sv
// Directed self-checking bench for mmio_issue_sched.
module tb_mmio_issue_sched;
    logic       clk = 1'b0;
    logic       rst;
    logic       mmio_0, mmio_1, mmio_2;
    logic [7:0] idx_0, idx_1, idx_2;
    logic       rdy_0, rdy_1, rdy_2;
    logic [7:0] rob_head;
    logic       flush_valid;
    logic [7:0] flush_robIdx;
    logic       wb_valid;
    logic [7:0] wb_robIdx;
    logic [1:0] wb_lane;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    mmio_issue_sched_if #(.ROB_IDX_W(8)) unc ();

    mmio_issue_sched #(.ROB_IDX_W(8)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .io_lsq_mmio_0             (mmio_0),
        .io_lsq_mmio_1             (mmio_1),
        .io_lsq_mmio_2             (mmio_2),
        .io_lsq_uop_0_robIdx_value (idx_0),
        .io_lsq_uop_1_robIdx_value (idx_1),
        .io_lsq_uop_2_robIdx_value (idx_2),
        .io_lsq_ready_0            (rdy_0),
        .io_lsq_ready_1            (rdy_1),
        .io_lsq_ready_2            (rdy_2),
        .rob_head                  (rob_head),
        .flush_valid               (flush_valid),
        .flush_robIdx              (flush_robIdx),
        .unc                       (unc),
        .wb_valid                  (wb_valid),
        .wb_robIdx                 (wb_robIdx),
        .wb_lane                   (wb_lane),
        .busy                      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_pulses();
        mmio_0 = 1'b0;
        mmio_1 = 1'b0;
        mmio_2 = 1'b0;
    endtask

    // Wait (bounded) for a request, check it, complete it with an immediate resp, check wb.
    task automatic serve(input logic [7:0] eidx, input logic [1:0] elane, input string tag);
        int n = 0;
        while (!unc.uncache_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " req_valid"}, unc.uncache_req_valid, 1);
        chk({tag, " req_robIdx"}, unc.uncache_req_robIdx, eidx);
        chk({tag, " req_lane"}, unc.uncache_req_lane, elane);
        unc.uncache_req_ready = 1'b1;
        tick();
        chk({tag, " single outstanding"}, unc.uncache_req_valid, 0);
        unc.uncache_resp_valid = 1'b1;
        tick();
        unc.uncache_resp_valid = 1'b0;
        chk({tag, " wb_valid"}, wb_valid, 1);
        chk({tag, " wb_robIdx"}, wb_robIdx, eidx);
        chk({tag, " wb_lane"}, wb_lane, elane);
    endtask

    initial begin
        rst = 1'b1;
        clr_pulses();
        idx_0 = 8'h00; idx_1 = 8'h00; idx_2 = 8'h00;
        rob_head = 8'h00;
        flush_valid = 1'b0;
        flush_robIdx = 8'h00;
        unc.uncache_req_ready = 1'b1;
        unc.uncache_resp_valid = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst req_valid", unc.uncache_req_valid, 0);
        chk("rst req_robIdx", unc.uncache_req_robIdx, 0);
        chk("rst req_lane", unc.uncache_req_lane, 0);
        chk("rst wb_valid", wb_valid, 0);
        chk("rst wb_robIdx", wb_robIdx, 0);
        chk("rst wb_lane", wb_lane, 0);
        chk("rst busy", busy, 0);
        chk("rst ready", {rdy_2, rdy_1, rdy_0}, 3'b111);
        rst = 1'b0;
        tick();

        // Single lane, resp two cycles after handshake
        rob_head = 8'h10;
        mmio_1 = 1'b1; idx_1 = 8'h10;
        tick();
        clr_pulses();
        chk("single ready_1 low", rdy_1, 0);
        chk("single no req yet", unc.uncache_req_valid, 0);
        tick();
        chk("single req_valid", unc.uncache_req_valid, 1);
        chk("single req_robIdx", unc.uncache_req_robIdx, 8'h10);
        chk("single req_lane", unc.uncache_req_lane, 1);
        chk("single busy", busy, 1);
        tick();
        chk("single req dropped", unc.uncache_req_valid, 0);
        tick();
        unc.uncache_resp_valid = 1'b1;
        chk("single no early wb", wb_valid, 0);
        tick();
        unc.uncache_resp_valid = 1'b0;
        chk("single wb_valid", wb_valid, 1);
        chk("single wb_robIdx", wb_robIdx, 8'h10);
        chk("single wb_lane", wb_lane, 1);
        chk("single ready_1 during wb", rdy_1, 0);
        tick();
        chk("single wb one cycle", wb_valid, 0);
        chk("single ready_1 back", rdy_1, 1);
        chk("single idle", busy, 0);

        // Ordering by ROB head
        rob_head = 8'h03;
        mmio_0 = 1'b1; idx_0 = 8'h05;
        mmio_1 = 1'b1; idx_1 = 8'h03;
        mmio_2 = 1'b1; idx_2 = 8'h04;
        tick();
        clr_pulses();
        chk("order ready all low", {rdy_2, rdy_1, rdy_0}, 3'b000);
        serve(8'h03, 2'd1, "order1");
        rob_head = 8'h04;
        chk("order1 no req in wb", unc.uncache_req_valid, 0);
        serve(8'h04, 2'd2, "order2");
        rob_head = 8'h05;
        serve(8'h05, 2'd0, "order3");
        tick();
        chk("order done idle", busy, 0);
        chk("order ready all high", {rdy_2, rdy_1, rdy_0}, 3'b111);

        // Wrap-around age compare under flush
        rob_head = 8'hFE;
        mmio_0 = 1'b1; idx_0 = 8'h01;
        mmio_2 = 1'b1; idx_2 = 8'hFF;
        tick();
        clr_pulses();
        flush_valid = 1'b1; flush_robIdx = 8'h00;
        tick();
        flush_valid = 1'b0;
        chk("wrap lane0 flushed", rdy_0, 1);
        chk("wrap lane2 kept", rdy_2, 0);
        chk("wrap no req", unc.uncache_req_valid, 0);
        rob_head = 8'hFF;
        serve(8'hFF, 2'd2, "wrap");
        tick();
        chk("wrap ready_2 back", rdy_2, 1);
        chk("wrap idle", busy, 0);

        // Backpressure, plus pulse into an occupied slot
        rob_head = 8'h30;
        unc.uncache_req_ready = 1'b0;
        mmio_0 = 1'b1; idx_0 = 8'h30;
        tick();
        clr_pulses();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp req_valid", unc.uncache_req_valid, 1);
            chk("bp req_robIdx", unc.uncache_req_robIdx, 8'h30);
            chk("bp req_lane", unc.uncache_req_lane, 0);
            if (i == 1) begin
                mmio_0 = 1'b1; idx_0 = 8'h31;
            end else begin
                clr_pulses();
            end
            tick();
        end
        clr_pulses();
        unc.uncache_req_ready = 1'b1;
        chk("bp 6th req_valid", unc.uncache_req_valid, 1);
        chk("bp 6th req_robIdx", unc.uncache_req_robIdx, 8'h30);
        tick();
        chk("bp handshake done", unc.uncache_req_valid, 0);
        unc.uncache_resp_valid = 1'b1;
        tick();
        unc.uncache_resp_valid = 1'b0;
        chk("bp wb_valid", wb_valid, 1);
        chk("bp wb_robIdx", wb_robIdx, 8'h30);
        tick();
        tick();
        chk("bp ready_0 back", rdy_0, 1);
        chk("bp no stray issue", busy, 0);

        // Flush of the selected slot while in REQ without handshake
        rob_head = 8'h20;
        unc.uncache_req_ready = 1'b0;
        mmio_1 = 1'b1; idx_1 = 8'h20;
        tick();
        clr_pulses();
        tick();
        chk("freq req_valid", unc.uncache_req_valid, 1);
        flush_valid = 1'b1; flush_robIdx = 8'h20;
        tick();
        flush_valid = 1'b0;
        chk("freq req dropped", unc.uncache_req_valid, 0);
        chk("freq idle", busy, 0);
        chk("freq ready_1", rdy_1, 1);
        tick();
        chk("freq no reissue", unc.uncache_req_valid, 0);

        // Same flush coincident with handshake: handshake wins
        mmio_1 = 1'b1; idx_1 = 8'h20;
        tick();
        clr_pulses();
        tick();
        chk("fhs req_valid", unc.uncache_req_valid, 1);
        unc.uncache_req_ready = 1'b1;
        flush_valid = 1'b1; flush_robIdx = 8'h20;
        tick();
        flush_valid = 1'b0;
        chk("fhs in wait busy", busy, 1);
        chk("fhs req dropped", unc.uncache_req_valid, 0);
        unc.uncache_resp_valid = 1'b1;
        tick();
        unc.uncache_resp_valid = 1'b0;
        chk("fhs wb_valid", wb_valid, 1);
        chk("fhs wb_robIdx", wb_robIdx, 8'h20);
        chk("fhs wb_lane", wb_lane, 1);
        tick();
        chk("fhs ready_1 back", rdy_1, 1);

        // Reset while in WAIT
        rob_head = 8'h40;
        mmio_2 = 1'b1; idx_2 = 8'h40;
        tick();
        clr_pulses();
        tick();
        chk("rwait req_valid", unc.uncache_req_valid, 1);
        tick();
        chk("rwait in wait", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rwait req_valid", unc.uncache_req_valid, 0);
        chk("rwait req_robIdx", unc.uncache_req_robIdx, 0);
        chk("rwait req_lane", unc.uncache_req_lane, 0);
        chk("rwait wb_valid", wb_valid, 0);
        chk("rwait wb_robIdx", wb_robIdx, 0);
        chk("rwait wb_lane", wb_lane, 0);
        chk("rwait busy", busy, 0);
        chk("rwait ready", {rdy_2, rdy_1, rdy_0}, 3'b111);
        unc.uncache_resp_valid = 1'b1;
        tick();
        unc.uncache_resp_valid = 1'b0;
        chk("rwait late resp no wb", wb_valid, 0);
        tick();
        chk("rwait late resp no wb 2", wb_valid, 0);
        chk("rwait still idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
